// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage: load/store opcodes,
// bus widths, FSM states, access sizes and opcode decode helpers.
package stage_mem_pkg;

    localparam int unsigned ALUOP_W   = 8;
    localparam int unsigned REGADDR_W = 5;

    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_ACCESS,
        MEM_DONE
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic is_signed_op(input logic [ALUOP_W-1:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LH_OP);
    endfunction

    function automatic mem_size_e op_size(input logic [ALUOP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
            default:                          return SZ_WORD;
        endcase
    endfunction

    function automatic logic [1:0] last_beat(input mem_size_e sz);
        case (sz)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ld_ext.sv
// Size/sign extension of an assembled little-endian load word.
module mem_ld_ext
    import stage_mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] asm_word,
    input  mem_size_e       size,
    input  logic            sign_ext,
    output logic [XLEN-1:0] word
);

    always_comb begin
        word = asm_word;
        case (size)
            SZ_BYTE: word = {{(XLEN-8){sign_ext & asm_word[7]}}, asm_word[7:0]};
            SZ_HALF: word = {{(XLEN-16){sign_ext & asm_word[15]}}, asm_word[15:0]};
            default: word = asm_word;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: performs loads/stores as byte beats on an
// 8-bit req/ack bus and stalls the pipeline until the access completes.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned BUS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALUOP_W-1:0]   aluop_i,
    input  logic [XLEN-1:0]      mem_addr_i,
    input  logic [XLEN-1:0]      rt_data_i,
    input  logic [REGADDR_W-1:0] reg_waddr_i,
    input  logic                 we_i,
    input  logic [XLEN-1:0]      reg_wdata_i,
    output logic [REGADDR_W-1:0] reg_waddr_o,
    output logic                 we_o,
    output logic [XLEN-1:0]      reg_wdata_o,
    output logic                 stallreq,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr_o,
    output logic [BUS_W-1:0]     mem_wdata,
    input  logic                 mem_ack,
    input  logic [BUS_W-1:0]     mem_rdata
);

    mem_state_e           state_q, state_d;
    logic [1:0]           beat_q;
    logic [XLEN-1:0]      addr_q;
    logic [XLEN-1:0]      sdata_q;
    logic [XLEN-1:0]      asm_q;
    mem_size_e            size_q;
    logic                 sign_q;
    logic                 store_q;
    logic                 we_q;
    logic [REGADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]      ext_word;
    logic                 last_q;

    assign last_q = (beat_q == last_beat(size_q));

    mem_ld_ext #(.XLEN(XLEN)) u_ld_ext (
        .asm_word (asm_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .word     (ext_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            asm_q   <= '0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            store_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                MEM_IDLE: begin
                    if (is_mem_op(aluop_i)) begin
                        addr_q  <= mem_addr_i;
                        sdata_q <= rt_data_i;
                        size_q  <= op_size(aluop_i);
                        sign_q  <= is_signed_op(aluop_i);
                        store_q <= is_store_op(aluop_i);
                        we_q    <= we_i;
                        waddr_q <= reg_waddr_i;
                        asm_q   <= '0;
                        beat_q  <= '0;
                    end
                end
                MEM_ACCESS: begin
                    if (mem_ack) begin
                        if (!store_q) asm_q[{beat_q, 3'b000} +: BUS_W] <= mem_rdata;
                        if (!last_q)  beat_q <= beat_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Everything is gated by rst so a mid-access reset drops the bus at once.
    always_comb begin
        state_d     = state_q;
        reg_waddr_o = '0;
        we_o        = 1'b0;
        reg_wdata_o = '0;
        stallreq    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr_o  = '0;
        mem_wdata   = '0;
        if (rst) begin
            case (state_q)
                MEM_IDLE: begin
                    if (is_mem_op(aluop_i)) begin
                        stallreq = 1'b1;
                        state_d  = MEM_ACCESS;
                    end else begin
                        reg_waddr_o = reg_waddr_i;
                        we_o        = we_i;
                        reg_wdata_o = reg_wdata_i;
                    end
                end
                MEM_ACCESS: begin
                    mem_req    = 1'b1;
                    stallreq   = 1'b1;
                    mem_we     = store_q;
                    mem_addr_o = addr_q + XLEN'(beat_q);
                    mem_wdata  = sdata_q[{beat_q, 3'b000} +: BUS_W];
                    if (mem_ack && last_q) state_d = MEM_DONE;
                end
                MEM_DONE: begin
                    reg_waddr_o = waddr_q;
                    we_o        = we_q & ~store_q;
                    reg_wdata_o = store_q ? '0 : ext_word;
                    state_d     = MEM_IDLE;
                end
                default: state_d = MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed plan steps plus random
// loads/stores against a byte-addressed memory model.
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, rt_data_i, reg_wdata_i;
    logic [4:0]  reg_waddr_i;
    logic        we_i;
    logic [4:0]  reg_waddr_o;
    logic        we_o;
    logic [31:0] reg_wdata_o;
    logic        stallreq, mem_req, mem_we;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int tests = 0;
    int fails = 0;
    logic [7:0] mem_model [logic [31:0]];
    logic [31:0] got;

    localparam logic [7:0] ADD_OP = 8'b0010_0000;

    stage_mem #(.XLEN(32), .BUS_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop_i),
        .mem_addr_i  (mem_addr_i),
        .rt_data_i   (rt_data_i),
        .reg_waddr_i (reg_waddr_i),
        .we_i        (we_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_waddr_o (reg_waddr_o),
        .we_o        (we_o),
        .reg_wdata_o (reg_wdata_o),
        .stallreq    (stallreq),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
        return mem_model[a];
    endfunction

    function automatic int nbytes(input logic [7:0] op);
        if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        return 1;
    endfunction

    // One load/store from issue through the DONE cycle; ignored inputs are scrambled during the access.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [4:0] wa, input logic wen, input int waits,
                           output logic [31:0] result);
        int          n   = nbytes(op);
        bit          st  = (op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP);
        bit          sgn = (op == EXE_LB_OP || op == EXE_LH_OP);
        longint      val = 0;
        int          stalls = 0;
        logic [7:0]  b;
        logic [31:0] ba;
        logic [31:0] exp_data;
        @(negedge clk);
        aluop_i = op; mem_addr_i = addr; rt_data_i = rt; reg_waddr_i = wa; we_i = wen;
        reg_wdata_i = $urandom; mem_ack = 1'b0;
        #1;
        chk("issue_stall", stallreq, 1);
        chk("issue_req", mem_req, 0);
        if (stallreq) stalls++;
        for (int i = 0; i < n; i++) begin
            ba = addr + 32'(i);
            b  = st ? rt[8*i +: 8] : rd_byte(ba);
            if (st) mem_model[ba] = b;
            val += longint'(b) << (8*i);
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                mem_addr_i = $urandom; rt_data_i = $urandom; reg_waddr_i = 5'($urandom);
                we_i = 1'($urandom); reg_wdata_i = $urandom;
                mem_ack   = (w == waits);
                mem_rdata = (w == waits) ? b : 8'($urandom);
                #1;
                chk("beat_req", mem_req, 1);
                chk("beat_addr", mem_addr_o, ba);
                chk("beat_we", mem_we, st);
                if (st) chk("beat_wdata", mem_wdata, b);
                if (stallreq) stalls++;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'($urandom);
        #1;
        if (sgn && val >= (longint'(1) << (8*n-1))) val -= (longint'(1) << (8*n));
        exp_data = st ? 32'h0 : val[31:0];
        chk("done_stall", stallreq, 0);
        chk("done_req", mem_req, 0);
        chk("done_we", we_o, st ? 1'b0 : wen);
        chk("done_waddr", reg_waddr_o, wa);
        chk("done_wdata", reg_wdata_o, exp_data);
        chk("stall_cycles", stalls, 1 + n * (waits + 1));
        result = reg_wdata_o;
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] op;
        ops = '{EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

        rst = 1'b0; aluop_i = EXE_LW_OP; mem_addr_i = 32'h1000; rt_data_i = 32'hFFFF_FFFF;
        reg_waddr_i = 5'd7; we_i = 1'b1; reg_wdata_i = 32'h1234; mem_ack = 1'b1; mem_rdata = 8'hAA;
        #2;
        chk("rst_stall", stallreq, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", we_o, 0);
        chk("rst_waddr", reg_waddr_o, 0);
        chk("rst_wdata", reg_wdata_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_mwdata", mem_wdata, 0);
        chk("rst_mwe", mem_we, 0);
        @(negedge clk);
        aluop_i = 8'h00; mem_ack = 1'b0;
        rst = 1'b1;

        mem_model[32'h1000] = 8'h78; mem_model[32'h1001] = 8'h56;
        mem_model[32'h1002] = 8'h34; mem_model[32'h1003] = 8'h12;
        run_mem(EXE_LW_OP, 32'h1000, 32'h0, 5'd3, 1'b1, 0, got);
        chk("lw_value", got, 32'h1234_5678);

        mem_model[32'h2003] = 8'h80;
        run_mem(EXE_LB_OP, 32'h2003, 32'h0, 5'd4, 1'b1, 0, got);
        chk("lb_value", got, 32'hFFFF_FF80);
        run_mem(EXE_LBU_OP, 32'h2003, 32'h0, 5'd4, 1'b1, 0, got);
        chk("lbu_value", got, 32'h0000_0080);
        mem_model[32'h2100] = 8'h34; mem_model[32'h2101] = 8'hF2;
        run_mem(EXE_LH_OP, 32'h2100, 32'h0, 5'd6, 1'b1, 0, got);
        chk("lh_value", got, 32'hFFFF_F234);

        run_mem(EXE_SH_OP, 32'h1001, 32'hABCD_1234, 5'd9, 1'b1, 0, got);
        run_mem(EXE_LHU_OP, 32'h1001, 32'h0, 5'd9, 1'b1, 1, got);
        chk("sh_readback", got, 32'h0000_1234);

        run_mem(EXE_SW_OP, 32'h5000, 32'hABCD_1234, 5'd2, 1'b1, 3, got);

        // Pass-through with a stray ack that must be ignored
        @(negedge clk);
        aluop_i = ADD_OP; reg_waddr_i = 5'd5; we_i = 1'b1; reg_wdata_i = 32'h55; mem_ack = 1'b1;
        #1;
        chk("add_waddr", reg_waddr_o, 5);
        chk("add_we", we_o, 1);
        chk("add_wdata", reg_wdata_o, 32'h55);
        chk("add_stall", stallreq, 0);
        chk("add_req", mem_req, 0);
        @(negedge clk);
        op = 8'($urandom);
        while (is_mem_op(op)) op = 8'($urandom);
        aluop_i = op; reg_wdata_i = $urandom; we_i = 1'b0; mem_ack = 1'b0;
        #1;
        chk("unk_req", mem_req, 0);
        chk("unk_stall", stallreq, 0);
        chk("unk_wdata", reg_wdata_o, reg_wdata_i);

        run_mem(EXE_LW_OP, 32'hFFFF_FFFE, 32'h0, 5'd8, 1'b1, 0, got);

        // Reset during beat 2 of a load
        @(negedge clk);
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h3000; reg_waddr_i = 5'd10; we_i = 1'b1; mem_ack = 1'b0;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'h11;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'h22;
        @(negedge clk); mem_ack = 1'b0;
        #1;
        chk("abort_beat2_addr", mem_addr_o, 32'h3002);
        #2 rst = 1'b0;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_stall", stallreq, 0);
        chk("abort_addr", mem_addr_o, 0);
        chk("abort_we", we_o, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_idle_stall", stallreq, 1);
        chk("post_rst_idle_req", mem_req, 0);
        aluop_i = 8'h00;
        #1;
        chk("post_rst_nop_stall", stallreq, 0);
        run_mem(EXE_LW_OP, 32'h3000, 32'h0, 5'd10, 1'b1, 0, got);

        for (int k = 0; k < 30; k++) begin
            run_mem(ops[$urandom_range(0, 7)], 32'h4000 + $urandom_range(0, 15), $urandom,
                    5'($urandom), 1'($urandom), $urandom_range(0, 2), got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory-access pipeline stage. Consumes the EX stage's load/store request (ex_aluop, mem_addr, rt_data) and the register write-back triple.
- Performs the access on an 8-bit req/ack memory bus, one byte per beat, little-endian.
- Holds the pipeline through stallreq until the access completes.
- Non-memory instructions pass straight through combinationally with no stall.

Parameters:
- XLEN, 32, datapath/address width; only 32 is supported.
- BUS_W, 8, memory-bus data width; fixed at 8, exists for documentation and asserts.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- aluop_i  in  `AluOpBus  operation from EX (ex_aluop)
- mem_addr_i  in  `MemAddrBus  effective address from EX
- rt_data_i  in  `RegBus  store data from EX
- reg_waddr_i  in  `RegAddrBus  destination register
- we_i  in  1  register write enable
- reg_wdata_i  in  `RegBus  EX result, for non-load instructions
- reg_waddr_o  out  `RegAddrBus  to WB
- we_o  out  1  to WB
- reg_wdata_o  out  `RegBus  to WB
- stallreq  out  1  freeze IF..EX and this stage's inputs
- mem_req  out  1  bus request
- mem_we  out  1  1 = write beat
- mem_addr_o  out  `MemAddrBus  byte address of the current beat
- mem_wdata  out  8  write byte
- mem_ack  in  1  beat complete; sampled on a clk edge while mem_req=1
- mem_rdata  in  8  read byte, valid with mem_ack

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (rst=0, asynchronous): state=IDLE, beat=0, all latches 0.
  - Outputs while in reset: mem_req=0, mem_we=0, mem_addr_o=0, mem_wdata=0, stallreq=0, we_o=0, reg_waddr_o=0, reg_wdata_o=0.
- IDLE, non-memory aluop:
  - Outputs = inputs combinationally (reg_waddr_o, we_o, reg_wdata_o).
  - stallreq=0, mem_req=0. Zero latency.
- IDLE, load/store aluop (LB, LH, LW, LBU, LHU, SB, SH, SW):
  - stallreq=1 combinationally in the same cycle.
  - At the edge: latch address, store data, size (1/2/4), signedness, direction, reg_waddr_i and we_i; clear the assembly register; beat=0; go to ACCESS.
- ACCESS:
  - mem_req=1, stallreq=1.
  - mem_addr_o = latched address + beat (32-bit wrap at 0xFFFFFFFF -> 0).
  - mem_we = store.
  - mem_wdata = store_data[8*beat +: 8].
  - mem_addr_o, mem_we and mem_wdata stay stable until mem_ack.
  - mem_ack=0: hold all bus outputs (unbounded wait states).
  - mem_ack=1, load: asm[8*beat +: 8] <= mem_rdata.
  - mem_ack=1, any access: if beat==size-1 go to DONE, else beat+1.
  - mem_ack may be high on the first ACCESS cycle.
- DONE (exactly one cycle):
  - mem_req=0, stallreq=0.
  - reg_waddr_o/we_o come from the latched copies.
  - reg_wdata_o:
    - LB: sign-extend asm[7:0]; LBU: zero-extend asm[7:0].
    - LH: sign-extend asm[15:0]; LHU: zero-extend asm[15:0].
    - LW: asm.
    - Stores: 0, and we_o=0 regardless of we_i.
  - Next state is IDLE unconditionally; the pipeline advances at this edge, so the same instruction is never re-issued.
- Stall count with zero-wait acks: 1 + size cycles (LW = 5), then one DONE cycle.
- Misaligned addresses are legal; byte-serial access handles them, no exception.
- mem_ack while mem_req=0 is ignored.
- Input changes during ACCESS are ignored; only latched values are used.
- Reset asserted mid-access: mem_req drops immediately (asynchronously), the partial access is abandoned, and the stage restarts in IDLE. The memory side must tolerate an abandoned request.
- Unknown aluop: treated as non-memory pass-through.

Decomposition:
- Shared defines package holds:
  - load/store aluop codes (EXE_LB_OP..EXE_SW_OP);
  - the bus macros `AluOpBus, `RegBus, `RegAddrBus, `MemAddrBus;
  - state encodings MEM_IDLE/MEM_ACCESS/MEM_DONE;
  - size encodings.
- One natural sub-module, mem_ld_ext: combinational size/sign extension of the assembled word, reused by any future cache path.
- The byte-beat FSM stays in stage_mem.

Test Plan:
- LW at 0x00001000, acks every cycle, rdata 0x78,0x56,0x34,0x12 -> mem_addr_o 0x1000..0x1003, stallreq high 5 cycles, DONE reg_wdata_o=0x12345678, we_o=1.
- LB then LBU at 0x2003, rdata 0x80 -> reg_wdata_o 0xFFFFFF80 then 0x00000080; LH with bytes 0x34,0xF2 -> 0xFFFFF234.
- SH, rt_data 0xABCD1234, addr 0x1001 (misaligned) -> write beats (0x1001,0x34), (0x1002,0x12), mem_we=1; DONE we_o=0.
- SW with mem_ack delayed 3 cycles per beat -> bus outputs held constant while waiting, stallreq high 1+4*4=17 cycles, bytes 0x34,0x12,0xCD,0xAB in order.
- ADD result 0x55 to x5 -> same-cycle pass-through, stallreq=0, mem_req never asserted; LW at 0xFFFFFFFE -> beat addresses wrap to 0x00000000, 0x00000001.
- rst pulled low during beat 2 of LW -> mem_req=0 and stallreq=0 without waiting for a clock, state IDLE; after release the next LW completes normally.
